// File: rtl/wb_spi_sram_bridge.sv
// wb_spi_sram_bridge
//   Wishbone slave that serves each single-byte access with one complete SPI SRAM
//   transaction (READ 0x03 / WRITE 0x02, 24-bit address, SPI mode 0, MSB first).
//   Each SPI bit takes two clock cycles: SCK low, then SCK high.
//
// Ports
//   clk_i                system clock, rising edge
//   rst_i                synchronous active-high reset
//   wbs_cyc_i/stb_i      Wishbone cycle / strobe
//   wbs_adr_i            byte address, zero-extended to 24 bits
//   wbs_we_i, wbs_dat_i  write enable / write byte
//   wbs_ack_o            registered one-cycle acknowledge
//   wbs_err_o/rty_o      always 0
//   wbs_dat_o            registered read byte
//   spi_cs_n_o, spi_sck_o, spi_mosi_o, spi_miso_i   SPI SRAM pins
module wb_spi_sram_bridge #(
   parameter int unsigned ADDR_WIDTH = 24
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
   input  logic                  wbs_we_i,
   input  logic [7:0]            wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic                  wbs_err_o,
   output logic                  wbs_rty_o,
   output logic [7:0]            wbs_dat_o,
   output logic                  spi_cs_n_o,
   output logic                  spi_sck_o,
   output logic                  spi_mosi_o,
   input  logic                  spi_miso_i
);

   if (ADDR_WIDTH > 24) begin : g_addr_check
      $error("wb_spi_sram_bridge: ADDR_WIDTH must be <= 24");
   end

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

   state_t      state;
   // Bits still to be sent after the one currently on MOSI (MSB first).
   logic [38:0] shreg;
   logic [5:0]  bit_cnt;
   logic        phase;
   logic [7:0]  rx;
   logic        we;

   logic        req;
   logic [23:0] addr_ext;
   logic [39:0] load_word;

   // Holding off while ack is high keeps a still-asserted strobe from being served twice.
   assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign addr_ext  = 24'(wbs_adr_i);
   assign load_word = {(wbs_we_i ? 8'h02 : 8'h03), addr_ext, (wbs_we_i ? wbs_dat_i : 8'h00)};

   assign wbs_err_o = 1'b0;
   assign wbs_rty_o = 1'b0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= StIdle;
         shreg      <= '0;
         bit_cnt    <= '0;
         phase      <= 1'b0;
         rx         <= '0;
         we         <= 1'b0;
         spi_cs_n_o <= 1'b1;
         spi_sck_o  <= 1'b0;
         spi_mosi_o <= 1'b0;
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= '0;
      end else begin
         wbs_ack_o <= 1'b0;
         unique case (state)
            StIdle: begin
               spi_cs_n_o <= 1'b1;
               spi_sck_o  <= 1'b0;
               spi_mosi_o <= 1'b0;
               if (req) begin
                  we         <= wbs_we_i;
                  spi_mosi_o <= load_word[39];
                  shreg      <= load_word[38:0];
                  spi_cs_n_o <= 1'b0;
                  bit_cnt    <= 6'd39;
                  phase      <= 1'b0;
                  state      <= StShift;
               end
            end
            StShift: begin
               if (!phase) begin
                  spi_sck_o <= 1'b1;
                  phase     <= 1'b1;
               end else begin
                  // End of the SCK-high cycle: sample MISO and present the next bit
                  // while SCK goes low, so MOSI never moves while SCK is high.
                  rx        <= {rx[6:0], spi_miso_i};
                  spi_sck_o <= 1'b0;
                  phase     <= 1'b0;
                  if (bit_cnt == 6'd0) begin
                     spi_cs_n_o <= 1'b1;
                     spi_mosi_o <= 1'b0;
                     state      <= StDone;
                  end else begin
                     spi_mosi_o <= shreg[38];
                     shreg      <= {shreg[37:0], 1'b0};
                     bit_cnt    <= bit_cnt - 6'd1;
                  end
               end
            end
            StDone: begin
               if (!we) begin
                  wbs_dat_o <= rx;
               end
               // An abandoned cycle still completes on the SPI side but is not acked.
               wbs_ack_o <= wbs_cyc_i;
               state     <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_spi_sram_bridge.sv
// Bench for wb_spi_sram_bridge: a behavioural SPI SRAM model, a table of accesses checked
// through a scoreboard, and hand-written sequences for back-to-back, abort, reset and
// 16-bit address cases.
module tb_wb_spi_sram_bridge;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cyc, stb, we, miso;
   logic [23:0] adr;
   logic [7:0]  wdat;
   logic        ack, err, rty, cs_n, sck, mosi;
   logic [7:0]  rdat;

   wb_spi_sram_bridge #(.ADDR_WIDTH(24)) u_dut (
      .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_adr_i(adr),
      .wbs_we_i(we), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty),
      .wbs_dat_o(rdat), .spi_cs_n_o(cs_n), .spi_sck_o(sck), .spi_mosi_o(mosi),
      .spi_miso_i(miso)
   );

   // 16-bit address instance, MISO tied low.
   logic        cyc16, stb16, we16, miso16;
   logic [15:0] adr16;
   logic [7:0]  wdat16, rdat16;
   logic        ack16, err16, rty16, cs16, sck16, mosi16;
   logic [39:0] frame16 = '0;

   wb_spi_sram_bridge #(.ADDR_WIDTH(16)) u_dut16 (
      .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc16), .wbs_stb_i(stb16), .wbs_adr_i(adr16),
      .wbs_we_i(we16), .wbs_dat_i(wdat16), .wbs_ack_o(ack16), .wbs_err_o(err16),
      .wbs_rty_o(rty16), .wbs_dat_o(rdat16), .spi_cs_n_o(cs16), .spi_sck_o(sck16),
      .spi_mosi_o(mosi16), .spi_miso_i(miso16)
   );

   always @(posedge sck16) frame16 = {frame16[38:0], mosi16};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // ---------------- SPI SRAM model ----------------
   logic [7:0]  mem [logic [23:0]];
   int          sck_cnt = 0;
   int          last_cnt = 0;
   logic [39:0] frame = '0;
   logic [39:0] last_frame = '0;
   logic [23:0] m_addr = '0;
   logic [7:0]  m_cmd = '0;
   int          total_sck = 0;

   always @(negedge cs_n) begin
      sck_cnt = 0;
      frame   = '0;
   end

   always @(posedge sck) begin
      total_sck++;
      if (cs_n === 1'b0) begin
         frame = {frame[38:0], mosi};
         sck_cnt++;
      end
   end

   // Data bits are presented after the falling SCK edge of the preceding bit.
   always @(negedge sck) begin
      logic [7:0] b;
      if (cs_n === 1'b0 && sck_cnt >= 32 && sck_cnt < 40) begin
         if (sck_cnt == 32) begin
            m_cmd  = frame[31:24];
            m_addr = frame[23:0];
         end
         if (m_cmd == 8'h03) begin
            b = mem.exists(m_addr) ? mem[m_addr] : 8'h00;
            #1 miso = b[39-sck_cnt];
         end
      end
   end

   always @(posedge cs_n) begin
      last_cnt   = sck_cnt;
      last_frame = frame;
      if (sck_cnt == 40 && frame[39:32] == 8'h02) mem[frame[31:8]] = frame[7:0];
   end

   // ---------------- monitors ----------------
   int   ack_count = 0;
   int   hi_run = 0;
   int   min_gap = 1000;
   bit   gap_armed = 1'b0;
   int   mosi_viol = 0;
   logic prev_mosi = 1'b0;

   always @(posedge clk) begin
      if (ack === 1'b1) ack_count++;
      if (cs_n === 1'b0) begin
         if (gap_armed && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
         gap_armed = 1'b1;
         hi_run    = 0;
      end else begin
         hi_run++;
      end
   end

   always @(negedge clk) begin
      if (sck === 1'b1 && mosi !== prev_mosi) mosi_viol++;
      prev_mosi = mosi;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic        we;
      logic [23:0] adr;
      logic [7:0]  wdat;
      logic [7:0]  exp_rdat;
      logic [39:0] exp_frame;
   } vec_t;

   vec_t sb[$];

   task automatic wait_ack(output int lat);
      bit found = 1'b0;
      lat = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (ack === 1'b1) found = 1'b1;
      end
      if (!found) lat = -1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   lat;
      vec_t e;
      cyc  = 1'b1;
      stb  = 1'b1;
      we   = v.we;
      adr  = v.adr;
      wdat = v.wdat;
      sb.push_back(v);
      wait_ack(lat);
      cyc = 1'b0;
      stb = 1'b0;
      check({tag, "_latency"}, 64'(lat), 64'd82);
      e = sb.pop_front();
      check({tag, "_rdat"}, 64'(rdat), 64'(e.exp_rdat));
      check({tag, "_frame"}, 64'(last_frame), 64'(e.exp_frame));
      check({tag, "_sck_edges"}, 64'(last_cnt), 64'd40);
      if (e.we) check({tag, "_mem"}, 64'(mem[e.adr]), 64'(e.wdat));
      @(negedge clk);
      check({tag, "_ack_single"}, 64'(ack), 64'd0);
   endtask

   vec_t tbl [6];
   int   lat, a0, s0, bad;

   initial begin
      tbl[0] = '{1'b0, 24'h800010, 8'h00, 8'hA5, 40'h03_800010_00};
      tbl[1] = '{1'b1, 24'h400002, 8'h3C, 8'hA5, 40'h02_400002_3C};
      tbl[2] = '{1'b0, 24'h400002, 8'h00, 8'h3C, 40'h03_400002_00};
      tbl[3] = '{1'b0, 24'h123456, 8'h00, 8'h5A, 40'h03_123456_00};
      tbl[4] = '{1'b1, 24'hFFFFFF, 8'hFF, 8'h5A, 40'h02_FFFFFF_FF};
      tbl[5] = '{1'b0, 24'hFFFFFF, 8'h00, 8'hFF, 40'h03_FFFFFF_00};

      mem[24'h800010] = 8'hA5;
      mem[24'h123456] = 8'h5A;
      mem[24'h000000] = 8'h7E;
      mem[24'h000001] = 8'hC3;

      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; miso = 1'b0;
      cyc16 = 1'b0; stb16 = 1'b0; we16 = 1'b0; adr16 = '0; wdat16 = '0; miso16 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_cs_n", 64'(cs_n), 64'd1);
      check("reset_sck", 64'(sck), 64'd0);
      check("reset_mosi", 64'(mosi), 64'd0);
      check("reset_ack", 64'(ack), 64'd0);
      check("reset_rdat", 64'(rdat), 64'd0);
      check("reset_err_rty", 64'({err, rty}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Back-to-back: cyc/stb held, read 0x000001 then write 0x99 to 0x000001.
      min_gap = 1000; gap_armed = 1'b0; a0 = ack_count;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'h000001; wdat = 8'h00;
      wait_ack(lat);
      check("b2b_rd_latency", 64'(lat), 64'd82);
      check("b2b_rd_rdat", 64'(rdat), 64'hC3);
      we = 1'b1; wdat = 8'h99;
      wait_ack(lat);
      check("b2b_wr_latency_ok", 64'(lat >= 82 && lat <= 83), 64'd1);
      check("b2b_wr_frame", 64'(last_frame), 64'h02_000001_99);
      cyc = 1'b0; stb = 1'b0;
      repeat (4) @(negedge clk);
      check("b2b_ack_count", 64'(ack_count - a0), 64'd2);
      check("b2b_cs_gap_ok", 64'(min_gap >= 2 && min_gap < 100), 64'd1);
      check("b2b_mem", 64'(mem[24'h000001]), 64'h99);
      check("b2b_rdat_kept", 64'(rdat), 64'hC3);

      // Abort: cyc dropped at A+20 of a write of 0x55 to 0x000100.
      a0 = ack_count;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h000100; wdat = 8'h55;
      repeat (20) @(posedge clk);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; adr = 24'h00FFFF; wdat = 8'hAA; we = 1'b0;
      repeat (100) @(negedge clk);
      check("abort_no_ack", 64'(ack_count - a0), 64'd0);
      check("abort_sck_edges", 64'(last_cnt), 64'd40);
      check("abort_frame", 64'(last_frame), 64'h02_000100_55);
      check("abort_mem", 64'(mem[24'h000100]), 64'h55);
      run_vec('{1'b0, 24'h000100, 8'h00, 8'h55, 40'h03_000100_00}, "after_abort");

      // Reset asserted at A+30 of a read.
      a0 = ack_count;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'h000001;
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_cs_n", 64'(cs_n), 64'd1);
      check("midrst_sck", 64'(sck), 64'd0);
      check("midrst_mosi", 64'(mosi), 64'd0);
      check("midrst_ack", 64'(ack), 64'd0);
      check("midrst_rdat", 64'(rdat), 64'd0);
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      repeat (100) @(negedge clk);
      check("midrst_no_ack", 64'(ack_count - a0), 64'd0);
      run_vec('{1'b0, 24'h000000, 8'h00, 8'h7E, 40'h03_000000_00}, "after_rst");

      // cyc without stb: nothing happens.
      s0 = total_sck; bad = 0;
      cyc = 1'b1; stb = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cs_n !== 1'b1) bad++;
      end
      cyc = 1'b0;
      check("idle_cs_n_high", 64'(bad), 64'd0);
      check("idle_no_sck", 64'(total_sck - s0), 64'd0);

      // 16-bit address instance.
      cyc16 = 1'b1; stb16 = 1'b1; we16 = 1'b0; adr16 = 16'hBEEF;
      lat = -1;
      for (int i = 1; i <= 300 && lat < 0; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (ack16 === 1'b1) lat = i;
      end
      cyc16 = 1'b0; stb16 = 1'b0;
      check("a16_latency", 64'(lat), 64'd82);
      check("a16_frame", 64'(frame16), 64'h03_00BEEF_00);
      check("a16_rdat", 64'(rdat16), 64'h00);

      check("mosi_stable_while_sck_high", 64'(mosi_viol), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
